// File: rtl/bit_population_cnt_pkg.sv
// rtl/bit_population_cnt_pkg.sv - shared helpers for the population counter tree
package bit_population_cnt_pkg;

    // Number of partial sums present after `level` pairwise reductions of `width` bits.
    function automatic int operands_at_level(input int width, input int level);
        return (width + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/bpc_add_level.sv
// rtl/bpc_add_level.sv - one registered adder-tree level: pairwise sums, odd operand passes through
module bpc_add_level
    import bit_population_cnt_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int IN_W = 1
) (
    input  logic                                 clk_i,
    input  logic                                 srst_i,
    input  logic [N_IN*IN_W-1:0]                 sums_i,
    input  logic                                 val_i,
    output logic [((N_IN+1)/2)*(IN_W+1)-1:0]     sums_o,
    output logic                                 val_o
);

    localparam int N_OUT = (N_IN + 1) / 2;
    localparam int OUT_W = IN_W + 1;

    logic [N_OUT*OUT_W-1:0] sums_d;
    logic [N_OUT*OUT_W-1:0] sums_q;
    logic                   val_q;

    for (genvar j = 0; j < N_IN / 2; j++) begin : g_pair
        assign sums_d[j*OUT_W +: OUT_W] = OUT_W'(sums_i[2*j*IN_W +: IN_W])
                                        + OUT_W'(sums_i[(2*j+1)*IN_W +: IN_W]);
    end

    if (N_IN % 2 == 1) begin : g_odd
        assign sums_d[(N_OUT-1)*OUT_W +: OUT_W] = {1'b0, sums_i[(N_IN-1)*IN_W +: IN_W]};
    end

    // Sums load only with a valid operand set, so idle cycles hold the last result.
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            val_q  <= 1'b0;
            sums_q <= '0;
        end else begin
            val_q <= val_i;
            if (val_i) begin
                sums_q <= sums_d;
            end
        end
    end

    assign sums_o = sums_q;
    assign val_o  = val_q;

endmodule

// File: rtl/bit_population_cnt.sv
// rtl/bit_population_cnt.sv - pipelined population counter, one word per clock
module bit_population_cnt
    import bit_population_cnt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     data_val_i,
    output logic [$clog2(WIDTH):0]   data_o,
    output logic                     data_val_o
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int CNT_W  = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] stage0_q;
    logic             val0_q;

    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            val0_q   <= 1'b0;
            stage0_q <= '0;
        end else begin
            val0_q <= data_val_i;
            if (data_val_i) begin
                stage0_q <= data_i;
            end
        end
    end

    if (LEVELS == 0) begin : g_no_tree
        assign data_o     = stage0_q[CNT_W-1:0];
        assign data_val_o = val0_q;
    end else begin : g_tree
        for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
            localparam int N_IN  = operands_at_level(WIDTH, k - 1);
            localparam int N_OUT = operands_at_level(WIDTH, k);

            logic [N_IN*k-1:0]      in_sum;
            logic                   in_val;
            logic [N_OUT*(k+1)-1:0] out_sum;
            logic                   out_val;

            // Level 1 consumes raw bits as 1-bit partial sums.
            if (k == 1) begin : g_src_bits
                assign in_sum = stage0_q;
                assign in_val = val0_q;
            end else begin : g_src_level
                assign in_sum = g_lvl[k-1].out_sum;
                assign in_val = g_lvl[k-1].out_val;
            end

            bpc_add_level #(
                .N_IN (N_IN),
                .IN_W (k)
            ) u_level (
                .clk_i  (clk_i),
                .srst_i (srst_i),
                .sums_i (in_sum),
                .val_i  (in_val),
                .sums_o (out_sum),
                .val_o  (out_val)
            );
        end

        assign data_o     = g_lvl[LEVELS].out_sum[CNT_W-1:0];
        assign data_val_o = g_lvl[LEVELS].out_val;
    end

endmodule

// File: tb/tb_bit_population_cnt.sv
// tb/tb_bit_population_cnt.sv - randomized self-checking bench over several word widths
module tb_bit_population_cnt;

    localparam int NW = 5;
    localparam int WS [NW] = '{8, 1, 5, 16, 32};
    localparam int HIST = 1024;

    logic        clk = 1'b0;
    logic        srst = 1'b0;
    logic        data_val = 1'b0;
    logic [31:0] word = '0;

    logic [5:0]  dout [NW];
    logic        vout [NW];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NW; gi++) begin : g_dut
        logic [$clog2(WS[gi]):0] d_g;
        logic                    v_g;

        bit_population_cnt #(.WIDTH(WS[gi])) dut (
            .clk_i      (clk),
            .srst_i     (srst),
            .data_i     (word[WS[gi]-1:0]),
            .data_val_i (data_val),
            .data_o     (d_g),
            .data_val_o (v_g)
        );

        assign dout[gi] = 6'(d_g);
        assign vout[gi] = v_g;
    end

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    bit         due [NW][HIST];
    logic [5:0] exp_at [NW][HIST];
    logic [5:0] last_cnt [NW];
    int         in_cnt [NW];
    int         out_cnt [NW];

    task automatic check(input string tag, input int w, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s width=%0d cycle=%0d got=%0d expected=%0d", tag, w, cyc, got, exp);
        end
    endtask

    function automatic int latency(input int i);
        return $clog2(WS[i]) + 1;
    endfunction

    function automatic logic [5:0] ref_pop(input int i, input logic [31:0] w);
        logic [31:0] mask;
        mask = (WS[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WS[i]) - 32'd1);
        return 6'($countones(w & mask));
    endfunction

    task automatic observe();
        for (int i = 0; i < NW; i++) begin
            if (due[i][cyc]) last_cnt[i] = exp_at[i][cyc];
            check("data_val_o", WS[i], 32'(vout[i]), 32'(due[i][cyc]));
            check("data_o", WS[i], 32'(dout[i]), 32'(last_cnt[i]));
            if (vout[i]) out_cnt[i]++;
        end
    endtask

    task automatic step(input bit v, input logic [31:0] w);
        data_val = v;
        word     = w;
        @(posedge clk);
        cyc++;
        if (cyc >= HIST - 40) begin
            $display("FAIL cycle_budget width=0 cycle=%0d got=%0d expected=%0d", cyc, cyc, HIST - 40);
            $fatal(1, "cycle budget exhausted");
        end
        if (v) begin
            for (int i = 0; i < NW; i++) begin
                due[i][cyc + latency(i) - 1]    = 1'b1;
                exp_at[i][cyc + latency(i) - 1] = ref_pop(i, w);
                in_cnt[i]++;
            end
        end
        #1;
        observe();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, $urandom);
    endtask

    // Called 1 time unit after an edge: asserts reset between edges and checks it acts at once.
    task automatic reset_pulse();
        data_val = 1'b0;
        #2 srst = 1'b0;
        #1;
        for (int i = 0; i < NW; i++) begin
            check("rst_val", WS[i], 32'(vout[i]), 32'd0);
            check("rst_data", WS[i], 32'(dout[i]), 32'd0);
            for (int c = cyc + 1; c < HIST; c++) due[i][c] = 1'b0;
            last_cnt[i] = '0;
        end
        #1 srst = 1'b1;
    endtask

    logic [31:0] stream_a [5] = '{32'h0F, 32'hF0, 32'hAA, 32'h55, 32'h3C};

    initial begin
        for (int i = 0; i < NW; i++) begin
            last_cnt[i] = '0;
            in_cnt[i]   = 0;
            out_cnt[i]  = 0;
        end

        data_val = 1'b1;
        word     = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NW; i++) begin
            check("reset_val", WS[i], 32'(vout[i]), 32'd0);
            check("reset_data", WS[i], 32'(dout[i]), 32'd0);
        end
        data_val = 1'b0;
        #3 srst = 1'b1;

        idle(2);
        reset_pulse();
        idle(2);

        step(1'b1, 32'h0000_00B2);
        idle(7);

        foreach (stream_a[j]) step(1'b1, 32'hFFFF_FF00 | stream_a[j]);
        idle(2);
        step(1'b1, 32'h0000_0000); idle(7);
        step(1'b1, 32'hFFFF_FFFF); idle(7);
        for (int i = 0; i < NW; i++) check("all_ones", WS[i], 32'(dout[i]), 32'(WS[i]));
        step(1'b1, 32'h0000_0080); idle(7);
        step(1'b1, 32'h0000_0001); idle(7);

        foreach (stream_a[j]) step(1'b1, (j == 4) ? 32'h0000_00FF : stream_a[j]);
        idle(7);

        step(1'b1, 32'hFFFF_FFFF);
        step(1'b1, 32'h1234_5678);
        step(1'b1, 32'h8000_0001);
        reset_pulse();
        idle(7);

        for (int i = 0; i < NW; i++) begin
            in_cnt[i]  = 0;
            out_cnt[i] = 0;
        end
        for (int k = 0; k < 40; k++) begin
            step(1'b1, $urandom);
            idle($urandom_range(0, 3));
        end
        for (int k = 0; k < 20; k++) step(1'b1, $urandom);
        idle(8);
        for (int i = 0; i < NW; i++) check("result_count", WS[i], 32'(out_cnt[i]), 32'(in_cnt[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
